preadder_mt: RTL and testbench
==============================

PREADDER_MT -- requirements
Module: preadder_mt

Interface
REQ-001 Parameter N_THREAD, default 4: number of interleaved threads with private history registers; legal range 2..16.
REQ-002 Parameter TW, default $clog2(N_THREAD): thread-index width; derived, never overridden.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rstn  input  1  reset, synchronous to clk, active-low.
REQ-005 valid_in  input  1  X, Y, mode1, mode2 and thread are valid this cycle.
REQ-006 X, Y  input  redundant_poly_L3  operand polynomials.
REQ-007 mode1, mode2  input  3  operation selects for Z0 and Z1.
REQ-008 thread  input  TW  thread index of the current operands.
REQ-009 clr_hist  input  1  qualified by valid_in: invalidate the history of `thread` before it is read.
REQ-010 valid_out  output  1  Z0/Z1 carry a result.
REQ-011 thread_out  output  TW  thread index of the result.
REQ-012 Z0, Z1  output  redundant_poly_L3  results.

Function
REQ-013 Each thread t holds hx[t], hy[t] (redundant_poly_L3) and a bit hv[t]; the read operand HX = hv[thread] ? hx[thread] : 0, HY likewise.
REQ-014 If clr_hist=1 with valid_in=1, HX and HY read as 0 in that cycle.
REQ-015 On valid_in=1: hx[thread]<=X, hy[thread]<=Y, hv[thread]<=1; the write takes priority over clr_hist, so hv ends at 1.
REQ-016 On valid_in=0, no history, hv or thread state changes.
REQ-017 mode1: 000 Z0=X; 001 Z0=X+HX; 010 Z0=X+Y; 011 Z0=X-HX; 1xx Z0=X.
REQ-018 mode2: 000 Z1=Y; 001 Z1=X-Y; 010 Z1=Y+HY; 011 Z1=Y-HY; 1xx Z1=Y.
REQ-019 Fixed latency is 2 cycles for every mode, pass-through included: inputs in cycle n give valid_out, thread_out, Z0 and Z1 in cycle n+2.
REQ-020 valid_out and thread_out are valid_in and thread delayed 2 cycles; there is no backpressure and no stall.
REQ-021 Adds and subtracts use redundant coefficient arithmetic with no modular reduction in this block; result type is redundant_poly_L3.
REQ-022 When valid_out=0, Z0 and Z1 hold their previous values.
REQ-023 Back-to-back operations on the same thread in consecutive cycles are legal: the second one reads the history written by the first.
REQ-024 An out-of-range thread (>= N_THREAD) is ignored for history writes, reads history as 0, and still produces a result.

Reset
REQ-025 While rstn=0 on a clock edge: hv[*]<=0, valid_out<=0, thread_out<=0, Z0<=0, Z1<=0, and both pipeline valid stages are cleared.
REQ-026 hx and hy are not reset; they are masked by hv.
REQ-027 Reset asserted mid-operation discards all in-flight results; the first valid_in after release reads history as 0.

Configuration
REQ-028 Macro PREADDER_MT_HIST_SUB_EN: when defined, modes 011 are implemented as in REQ-017/018.
REQ-029 When PREADDER_MT_HIST_SUB_EN is undefined: the history subtractors are not instantiated, mode 011 behaves as pass-through (Z0=X, Z1=Y), and latency is unchanged.

Structure
REQ-030 redundant_poly_L3 and the adder come from PARAMS_BN254_d0; the mode encodings (MODE_PASS, MODE_HADD, MODE_XY, MODE_HSUB) become localparams added to that package.
REQ-031 All arithmetic uses the existing poly_adder_L3_L3 with LATENCY(1), followed by one output register stage; pass-through paths use 2 matching delay registers.
REQ-032 No new sub-module; the history file is inline register arrays.

Verification
REQ-033 Reset, then thread 0 with X=all coeff 3, mode1=001 -> Z0=all 3 at n+2 (no history).
REQ-034 Thread 1: X=5, then X=7, both mode1=001, consecutive cycles -> Z0=5, then 12, in consecutive cycles.
REQ-035 Threads 0,1,2,3 interleaved with Y=1,2,3,4, then Y=10 each with mode2=010 -> Z1=11,12,13,14 with matching thread_out.
REQ-036 X=9, Y=4, mode1=010, mode2=001 -> Z0=13, Z1=5; mode 000 gives X/Y at the same cycle n+2.
REQ-037 Thread 2 with history 6, clr_hist=1, X=2, mode1=011 -> Z0=2 (macro on) or 2 (pass, macro off); next X=1, mode 011 -> Z0=-1 (macro on) or 1 (macro off).
REQ-038 rstn low for one cycle with 2 results in flight -> valid_out=0 for the following 2 cycles, hv cleared.

Source files
------------

// File: rtl/PARAMS_BN254_d0.sv
// Shared types for the BN254 degree-0 datapath.
//   redundant_poly_L3 : NCOEF signed coefficients of COEF_W bits each, kept in
//                       redundant (unreduced) form; adds/subtracts simply wrap.
//   MODE_*            : operation selects used by preadder_mt (mode1/mode2).
// No ports (package).
package PARAMS_BN254_d0;

  localparam int COEF_W = 16;
  localparam int NCOEF  = 4;

  typedef logic signed [COEF_W-1:0] coef_t;
  typedef coef_t [NCOEF-1:0]        redundant_poly_L3;

  // mode1: PASS Z0=X, HADD Z0=X+HX, XY Z0=X+Y, HSUB Z0=X-HX
  // mode2: PASS Z1=Y, HADD Z1=X-Y,  XY Z1=Y+HY, HSUB Z1=Y-HY
  localparam logic [2:0] MODE_PASS = 3'b000;
  localparam logic [2:0] MODE_HADD = 3'b001;
  localparam logic [2:0] MODE_XY   = 3'b010;
  localparam logic [2:0] MODE_HSUB = 3'b011;

endpackage

// File: rtl/poly_adder_L3_L3.sv
// Coefficient-wise add/subtract of two redundant_poly_L3 values, no modular
// reduction. LATENCY 0 is combinational, any other value gives one register.
// Ports:
//   clk  in  clock
//   a, b in  operands
//   sub  in  1: s = a - b, 0: s = a + b
//   s    out result
module poly_adder_L3_L3
  import PARAMS_BN254_d0::*;
#(
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  redundant_poly_L3 a,
  input  redundant_poly_L3 b,
  input  logic             sub,
  output redundant_poly_L3 s
);

  redundant_poly_L3 sum_c;

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < NCOEF; i++) begin
      sum_c[i] = sub ? (a[i] - b[i]) : (a[i] + b[i]);
    end
  end

  if (LATENCY == 0) begin : g_comb
    assign s = sum_c;
  end else begin : g_reg
    always_ff @(posedge clk) begin
      s <= sum_c;
    end
  end

endmodule

// File: rtl/preadder_mt.sv
// Multi-threaded pre-adder. Each of N_THREAD interleaved threads keeps a
// private copy of its previous X/Y operands (history) that modes may add to or
// subtract from the current operands. Fixed 2-cycle latency in every mode.
// Optional feature: define PREADDER_MT_HIST_SUB_EN to implement the history
// subtract modes (011); without it mode 011 is a plain pass-through.
// Ports:
//   clk         in  clock
//   rstn        in  synchronous active-low reset
//   valid_in    in  operands valid this cycle
//   X, Y        in  operand polynomials
//   mode1/mode2 in  operation selects for Z0/Z1
//   thread      in  thread index of the operands
//   clr_hist    in  (with valid_in) read the thread's history as zero
//   valid_out   out Z0/Z1 carry a result
//   thread_out  out thread index of the result
//   Z0, Z1      out results, held while valid_out=0
module preadder_mt
  import PARAMS_BN254_d0::*;
#(
  parameter int N_THREAD = 4,
  parameter int TW       = $clog2(N_THREAD)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             valid_in,
  input  redundant_poly_L3 X,
  input  redundant_poly_L3 Y,
  input  logic [2:0]       mode1,
  input  logic [2:0]       mode2,
  input  logic [TW-1:0]    thread,
  input  logic             clr_hist,
  output logic             valid_out,
  output logic [TW-1:0]    thread_out,
  output redundant_poly_L3 Z0,
  output redundant_poly_L3 Z1
);

  redundant_poly_L3      hx [N_THREAD];
  redundant_poly_L3      hy [N_THREAD];
  logic [N_THREAD-1:0]   hv;

  logic             thr_ok_p0, hit_p0;
  redundant_poly_L3 hx_p0, hy_p0, b0_p0, a1_p0, b1_p0;
  logic             use0_p0, use1_p0, sub0_p0, sub1_p0;

  logic             vld_p1, use0_p1, use1_p1;
  logic [TW-1:0]    thread_p1;
  redundant_poly_L3 x_p1, y_p1, s0_p1, s1_p1;

  // ---- stage p0: history read and operand selection ----
  always_comb begin
    thr_ok_p0 = ({1'b0, thread} < (TW+1)'(N_THREAD));
    hit_p0    = thr_ok_p0 && hv[thread] && !clr_hist;
    hx_p0     = hit_p0 ? hx[thread] : '0;
    hy_p0     = hit_p0 ? hy[thread] : '0;

    use0_p0 = 1'b0;
    sub0_p0 = 1'b0;
    b0_p0   = '0;
    case (mode1)
      MODE_HADD: begin use0_p0 = 1'b1; b0_p0 = hx_p0; end
      MODE_XY:   begin use0_p0 = 1'b1; b0_p0 = Y;     end
`ifdef PREADDER_MT_HIST_SUB_EN
      MODE_HSUB: begin use0_p0 = 1'b1; sub0_p0 = 1'b1; b0_p0 = hx_p0; end
`endif
      default: ;
    endcase

    // Z1 adder: mode2=001 is X-Y, so its first operand is X rather than Y.
    use1_p0 = 1'b0;
    sub1_p0 = 1'b0;
    a1_p0   = Y;
    b1_p0   = '0;
    case (mode2)
      MODE_HADD: begin use1_p0 = 1'b1; sub1_p0 = 1'b1; a1_p0 = X; b1_p0 = Y; end
      MODE_XY:   begin use1_p0 = 1'b1; b1_p0 = hy_p0; end
`ifdef PREADDER_MT_HIST_SUB_EN
      MODE_HSUB: begin use1_p0 = 1'b1; sub1_p0 = 1'b1; b1_p0 = hy_p0; end
`endif
      default: ;
    endcase
  end

  // History write wins over clr_hist; a back-to-back op on the same thread
  // reads this value next cycle, so no bypass is needed.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      hv <= '0;
    end else if (valid_in && thr_ok_p0) begin
      hv[thread] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (valid_in && thr_ok_p0) begin
      hx[thread] <= X;
      hy[thread] <= Y;
    end
  end

  // ---- stage p1: adders (registered inside) and matching pass-through delay ----
  poly_adder_L3_L3 #(.LATENCY(1)) u_add0 (
    .clk (clk),
    .a   (X),
    .b   (b0_p0),
    .sub (sub0_p0),
    .s   (s0_p1)
  );

  poly_adder_L3_L3 #(.LATENCY(1)) u_add1 (
    .clk (clk),
    .a   (a1_p0),
    .b   (b1_p0),
    .sub (sub1_p0),
    .s   (s1_p1)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= valid_in;
    end
  end

  always_ff @(posedge clk) begin
    thread_p1 <= thread;
    x_p1      <= X;
    y_p1      <= Y;
    use0_p1   <= use0_p0;
    use1_p1   <= use1_p0;
  end

  // ---- stage p2: output register ----
  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_out  <= 1'b0;
      thread_out <= '0;
      Z0         <= '0;
      Z1         <= '0;
    end else begin
      valid_out  <= vld_p1;
      thread_out <= thread_p1;
      if (vld_p1) begin
        Z0 <= use0_p1 ? s0_p1 : x_p1;
        Z1 <= use1_p1 ? s1_p1 : y_p1;
      end
    end
  end

endmodule

// File: tb/tb_preadder_mt.sv
module tb_preadder_mt;
  import PARAMS_BN254_d0::*;

  localparam int N_THREAD = 4;
  localparam int TW       = 2;

`ifdef PREADDER_MT_HIST_SUB_EN
  localparam bit HSUB_ON  = 1'b1;
  localparam int HSUB_Z0  = -1;
`else
  localparam bit HSUB_ON  = 1'b0;
  localparam int HSUB_Z0  = 1;
`endif

  logic             clk, rstn, valid_in, clr_hist;
  redundant_poly_L3 X, Y, Z0, Z1;
  logic [2:0]       mode1, mode2;
  logic [TW-1:0]    thread, thread_out;
  logic             valid_out;

  preadder_mt #(.N_THREAD(N_THREAD)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .valid_in   (valid_in),
    .X          (X),
    .Y          (Y),
    .mode1      (mode1),
    .mode2      (mode2),
    .thread     (thread),
    .clr_hist   (clr_hist),
    .valid_out  (valid_out),
    .thread_out (thread_out),
    .Z0         (Z0),
    .Z1         (Z1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: per-thread history as plain integers, results delayed
  // through a two-slot list.
  int m_hx [N_THREAD][NCOEF];
  int m_hy [N_THREAD][NCOEF];
  bit m_hv [N_THREAD];

  typedef struct {
    bit               v;
    int               t;
    redundant_poly_L3 z0;
    redundant_poly_L3 z1;
  } res_t;

  res_t m_pend, m_out;

  function automatic redundant_poly_L3 splat(int v);
    redundant_poly_L3 p;
    for (int i = 0; i < NCOEF; i++) p[i] = coef_t'(v);
    return p;
  endfunction

  function automatic res_t model_eval();
    res_t r;
    int x, y, hxv, hyv, z0, z1;
    bit hit;
    hit  = (int'(thread) < N_THREAD) && m_hv[thread] && !clr_hist;
    r.v  = valid_in;
    r.t  = int'(thread);
    for (int i = 0; i < NCOEF; i++) begin
      x   = int'(X[i]);
      y   = int'(Y[i]);
      hxv = hit ? m_hx[thread][i] : 0;
      hyv = hit ? m_hy[thread][i] : 0;
      case (mode1)
        3'd1:    z0 = x + hxv;
        3'd2:    z0 = x + y;
        3'd3:    z0 = HSUB_ON ? x - hxv : x;
        default: z0 = x;
      endcase
      case (mode2)
        3'd1:    z1 = x - y;
        3'd2:    z1 = y + hyv;
        3'd3:    z1 = HSUB_ON ? y - hyv : y;
        default: z1 = y;
      endcase
      r.z0[i] = coef_t'(z0);
      r.z1[i] = coef_t'(z1);
    end
    return r;
  endfunction

  task automatic model_edge();
    res_t r;
    if (!rstn) begin
      m_out.v  = 1'b0;
      m_out.t  = 0;
      m_out.z0 = '0;
      m_out.z1 = '0;
      m_pend.v = 1'b0;
      for (int t = 0; t < N_THREAD; t++) m_hv[t] = 1'b0;
    end else begin
      r = model_eval();
      m_out.v = m_pend.v;
      m_out.t = m_pend.t;
      if (m_pend.v) begin
        m_out.z0 = m_pend.z0;
        m_out.z1 = m_pend.z1;
      end
      m_pend = r;
      if (valid_in && int'(thread) < N_THREAD) begin
        for (int i = 0; i < NCOEF; i++) begin
          m_hx[thread][i] = int'(X[i]);
          m_hy[thread][i] = int'(Y[i]);
        end
        m_hv[thread] = 1'b1;
      end
    end
  endtask

  task automatic check(string name, bit ev, int et, redundant_poly_L3 ez0, redundant_poly_L3 ez1);
    n_vec++;
    if (valid_out !== ev || (ev && thread_out !== TW'(et)) || Z0 !== ez0 || Z1 !== ez1) begin
      n_err++;
      $display("FAIL %s: got valid=%0b thr=%0d Z0=%h Z1=%h, want valid=%0b thr=%0d Z0=%h Z1=%h",
               name, valid_out, thread_out, Z0, Z1, ev, et, ez0, ez1);
    end
  endtask

  typedef struct {
    bit       rst;
    bit       vin;
    int       thr;
    bit       clr;
    bit [2:0] m1;
    bit [2:0] m2;
    int       x;
    int       y;
    bit       ev;
    int       et;
    int       ez0;
    int       ez1;
  } vec_t;

  function automatic vec_t mk(bit rst, bit vin, int thr, bit clr, bit [2:0] m1, bit [2:0] m2,
                              int x, int y, bit ev, int et, int ez0, int ez1);
    vec_t v;
    v.rst = rst; v.vin = vin; v.thr = thr; v.clr = clr; v.m1 = m1; v.m2 = m2;
    v.x = x; v.y = y; v.ev = ev; v.et = et; v.ez0 = ez0; v.ez1 = ez1;
    return v;
  endfunction

  localparam int NT = 30;
  vec_t tbl [NT];

  initial begin
    // Each row: inputs for one cycle, then the outputs expected just after
    // that cycle's clock edge (i.e. the result of the previous row).
    //            rst vin thr clr m1 m2  x   y    ev et  ez0      ez1
    tbl[0]  = mk(1, 0, 0, 0, 0, 0,  0,  0,   0, 0,  0,       0);
    tbl[1]  = mk(1, 0, 0, 0, 0, 0,  0,  0,   0, 0,  0,       0);
    tbl[2]  = mk(0, 1, 0, 0, 1, 0,  3,  0,   0, 0,  0,       0);
    tbl[3]  = mk(0, 1, 1, 0, 1, 0,  5,  0,   1, 0,  3,       0);
    tbl[4]  = mk(0, 1, 1, 0, 1, 0,  7,  0,   1, 1,  5,       0);
    tbl[5]  = mk(0, 1, 0, 0, 0, 0,  0,  1,   1, 1,  12,      0);
    tbl[6]  = mk(0, 1, 1, 0, 0, 0,  0,  2,   1, 0,  0,       1);
    tbl[7]  = mk(0, 1, 2, 0, 0, 0,  0,  3,   1, 1,  0,       2);
    tbl[8]  = mk(0, 1, 3, 0, 0, 0,  0,  4,   1, 2,  0,       3);
    tbl[9]  = mk(0, 1, 0, 0, 0, 2,  0,  10,  1, 3,  0,       4);
    tbl[10] = mk(0, 1, 1, 0, 0, 2,  0,  10,  1, 0,  0,       11);
    tbl[11] = mk(0, 1, 2, 0, 0, 2,  0,  10,  1, 1,  0,       12);
    tbl[12] = mk(0, 1, 3, 0, 0, 2,  0,  10,  1, 2,  0,       13);
    tbl[13] = mk(0, 1, 0, 0, 2, 1,  9,  4,   1, 3,  0,       14);
    tbl[14] = mk(0, 1, 0, 0, 0, 0,  9,  4,   1, 0,  13,      5);
    tbl[15] = mk(0, 1, 2, 0, 0, 0,  6,  6,   1, 0,  9,       4);
    tbl[16] = mk(0, 1, 2, 1, 3, 0,  2,  0,   1, 2,  6,       6);
    tbl[17] = mk(0, 1, 2, 0, 3, 0,  1,  0,   1, 2,  2,       0);
    tbl[18] = mk(0, 0, 0, 0, 0, 0,  0,  0,   1, 2,  HSUB_Z0, 0);
    tbl[19] = mk(0, 0, 0, 0, 0, 0,  0,  0,   0, 0,  HSUB_Z0, 0);
    tbl[20] = mk(0, 1, 1, 0, 0, 0,  20, 21,  0, 0,  HSUB_Z0, 0);
    tbl[21] = mk(0, 1, 2, 0, 0, 0,  22, 23,  1, 1,  20,      21);
    tbl[22] = mk(1, 0, 0, 0, 0, 0,  0,  0,   0, 0,  0,       0);
    tbl[23] = mk(0, 0, 0, 0, 0, 0,  0,  0,   0, 0,  0,       0);
    tbl[24] = mk(0, 1, 1, 0, 1, 2,  4,  5,   0, 0,  0,       0);
    tbl[25] = mk(0, 1, 3, 0, 5, 7,  8,  9,   1, 1,  4,       5);
    tbl[26] = mk(0, 0, 1, 0, 0, 0,  0,  0,   1, 3,  8,       9);
    tbl[27] = mk(0, 0, 1, 0, 1, 2,  50, 50,  0, 0,  8,       9);
    tbl[28] = mk(0, 1, 1, 0, 1, 2,  1,  1,   0, 0,  8,       9);
    tbl[29] = mk(0, 0, 0, 0, 0, 0,  0,  0,   1, 1,  5,       6);

    rstn = 1'b0; valid_in = 1'b0; clr_hist = 1'b0; thread = '0;
    mode1 = '0; mode2 = '0; X = '0; Y = '0;
    m_pend.v = 1'b0; m_out.v = 1'b0; m_out.t = 0; m_out.z0 = '0; m_out.z1 = '0;
    for (int t = 0; t < N_THREAD; t++) m_hv[t] = 1'b0;

    @(posedge clk);
    #1;

    for (int k = 0; k < NT; k++) begin
      rstn     = !tbl[k].rst;
      valid_in = tbl[k].vin;
      thread   = TW'(tbl[k].thr);
      clr_hist = tbl[k].clr;
      mode1    = tbl[k].m1;
      mode2    = tbl[k].m2;
      X        = splat(tbl[k].x);
      Y        = splat(tbl[k].y);
      @(posedge clk);
      model_edge();
      #1;
      check($sformatf("tbl%0d", k), tbl[k].ev, tbl[k].et, splat(tbl[k].ez0), splat(tbl[k].ez1));
      check($sformatf("tblmodel%0d", k), m_out.v, m_out.t, m_out.z0, m_out.z1);
    end

    for (int c = 0; c < 500; c++) begin
      rstn     = ($urandom_range(0, 59) != 0);
      valid_in = ($urandom_range(0, 9) < 7);
      thread   = TW'($urandom_range(0, N_THREAD - 1));
      clr_hist = ($urandom_range(0, 7) == 0);
      mode1    = 3'($urandom_range(0, 7));
      mode2    = 3'($urandom_range(0, 7));
      for (int i = 0; i < NCOEF; i++) begin
        X[i] = coef_t'(int'($urandom_range(0, 4000)) - 2000);
        Y[i] = coef_t'(int'($urandom_range(0, 4000)) - 2000);
      end
      @(posedge clk);
      model_edge();
      #1;
      check($sformatf("rand%0d", c), m_out.v, m_out.t, m_out.z0, m_out.z1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
